// File: rtl/gray2bin.sv
// Gray-code to binary converter with one registered output stage.
// A captured word appears on bin with out_valid one clock after in_valid.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin
);

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] r_bin;
  logic             r_out_valid;

  // Each binary bit is the XOR of the gray bits at and above it.
  always_comb begin
    // NOTE: default first so every bit is assigned on every pass and no latch is inferred.
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(gray >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, because bin must read 0 during reset.
      r_bin       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_bin <= w_bin;
      end
    end
  end

  assign bin       = r_bin;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_gray2bin.sv
// Scoreboarded bench for gray2bin at WIDTH 4, 1 and 8, driven side by side.
// Expected words come from a search-based inverse of the gray mapping.
module tb_gray2bin;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       iv4, iv1, iv8;
  logic [3:0] g4;
  logic [0:0] g1;
  logic [7:0] g8;
  logic       ov4, ov1, ov8;
  logic [3:0] b4;
  logic [0:0] b1;
  logic [7:0] b8;

  exp_t q[3][$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  gray2bin #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .gray(g4),
                              .out_valid(ov4), .bin(b4));
  gray2bin #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .gray(g1),
                              .out_valid(ov1), .bin(b1));
  gray2bin #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .gray(g8),
                              .out_valid(ov8), .bin(b8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the binary value whose gray encoding b^(b>>1) equals g.
  function automatic logic [7:0] ref_g2b(input int w, input logic [7:0] g);
    for (int b = 0; b < (1 << w); b++) begin
      if (((b ^ (b >> 1)) & 32'hFF) == {24'd0, g}) return 8'(b);
    end
    return 8'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic mon(input int k, input int w, input logic ov, input logic [7:0] b);
    exp_t       e;
    logic [7:0] mask;
    mask = 8'((9'h1 << w) - 9'h1);
    if (ov !== 1'b1) return;
    if (q[k].size() == 0) begin
      n_checks++;
      $display("FAIL w%0d_spurious_valid: got out_valid=1 expected 0 at cycle %0d", w, cyc);
    end else begin
      e = q[k].pop_front();
      check($sformatf("w%0d_latency", w), cyc, e.cyc);
      check($sformatf("w%0d_bin", w), {24'd0, b}, {24'd0, e.bin});
      check($sformatf("w%0d_roundtrip", w), {24'd0, (b ^ (b >> 1)) & mask}, {24'd0, e.gray});
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, ov4, {4'd0, b4});
    mon(1, 1, ov1, {7'd0, b1});
    mon(2, 8, ov8, b8);
  end

  task automatic issue(input int k, input logic v, input logic [7:0] g, input logic [7:0] e);
    case (k)
      0: begin iv4 = v; g4 = g[3:0]; end
      1: begin iv1 = v; g1 = g[0:0]; end
      default: begin iv8 = v; g8 = g; end
    endcase
    if (v) q[k].push_back('{bin: e, gray: g, cyc: cyc + 1});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w4_bin"}, {28'd0, b4}, 32'd0);
    check({tag, "_w4_valid"}, {31'd0, ov4}, 32'd0);
    check({tag, "_w1_bin"}, {31'd0, b1}, 32'd0);
    check({tag, "_w8_bin"}, {24'd0, b8}, 32'd0);
    check({tag, "_w8_valid"}, {31'd0, ov8}, 32'd0);
  endtask

  logic [7:0] spec_tab[16];
  logic [7:0] rg;
  logic       rv;

  initial begin
    spec_tab = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd7, 8'd6, 8'd4, 8'd5,
                 8'd15, 8'd14, 8'd12, 8'd13, 8'd8, 8'd9, 8'd11, 8'd10};
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
    g4 = '0; g1 = '0; g8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // Exhaustive WIDTH=4 against the published table, back to back.
    for (int g = 0; g < 16; g++) begin
      issue(0, 1'b1, 8'(g), spec_tab[g]);
      next_cycle();
    end

    // Spot values, including all-ones gray.
    issue(0, 1'b1, 8'h02, 8'h03); next_cycle();
    issue(0, 1'b1, 8'h08, 8'h0F); next_cycle();
    issue(0, 1'b1, 8'h0F, 8'h0A); next_cycle();

    // in_valid pattern 1,1,0,1.
    for (int i = 0; i < 4; i++) begin
      rg = 8'($urandom_range(0, 15));
      issue(0, i != 2, rg, ref_g2b(4, rg));
      next_cycle();
    end

    // Hold: bin keeps 0100 while in_valid=0 and gray=1111.
    issue(0, 1'b1, 8'h06, 8'h04);
    next_cycle();
    issue(0, 1'b0, 8'h0F, 8'h00);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("hold_bin", {28'd0, b4}, 32'h4);
      check("hold_valid", {31'd0, ov4}, 32'd0);
    end
    next_cycle();

    // Reset mid-stream: the captured word is discarded before it is sampled.
    issue(0, 1'b1, 8'h0D, 8'h09);
    issue(2, 1'b1, 8'hA5, ref_g2b(8, 8'hA5));
    next_cycle();
    issue(0, 1'b0, 8'h00, 8'h00);
    issue(2, 1'b0, 8'h00, 8'h00);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) q[k].delete();
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("rst_held");
    next_cycle();
    @(negedge clk);
    check_reset_outputs("rst_held2");
    next_cycle();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_w4_bin", {28'd0, b4}, 32'd0);
      next_cycle();
    end

    // Randomised traffic on all three widths.
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rg = 8'($urandom_range(0, 15));
      issue(0, rv, rg, ref_g2b(4, rg));
      rv = ($urandom_range(0, 3) != 0);
      rg = 8'($urandom_range(0, 1));
      issue(1, rv, rg, ref_g2b(1, rg));
      rv = ($urandom_range(0, 3) != 0);
      rg = 8'($urandom_range(0, 255));
      issue(2, rv, rg, ref_g2b(8, rg));
      next_cycle();
    end
    issue(0, 1'b0, 8'h0F, 8'h00);
    issue(1, 1'b0, 8'h01, 8'h00);
    issue(2, 1'b0, 8'hFF, 8'h00);
    repeat (3) next_cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_q%0d", k), q[k].size(), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
